// File: rtl/exmem_skid_reg.sv
// EX/MEM pipeline register with a valid/ready handshake, a one-entry skid
// buffer and a synchronous flush. The main entry drives the outputs and the
// skid entry catches the one beat that arrives while the memory stage stalls.
// inReady is the inverse of the skid valid bit, so it is driven straight from
// a flop and has no combinational path from outReady or flush.
// Optional feature: define EXMEM_STALL_CNT_EN to build the 16-bit saturating
// stallCycles counter and its port.
module exmem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              inValid,
    output logic              inReady,
    input  logic [WB_W-1:0]   WB,
    input  logic [M_W-1:0]    M,
    input  logic [DATA_W-1:0] addResult,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] readData2,
    input  logic [REG_W-1:0]  writeBack,
    input  logic              zero,
    output logic              outValid,
    input  logic              outReady,
    output logic [WB_W-1:0]   outWB,
    output logic [M_W-1:0]    outM,
    output logic [DATA_W-1:0] outAddResult,
    output logic [DATA_W-1:0] outALUResult,
    output logic [DATA_W-1:0] outReadData2,
    output logic [REG_W-1:0]  outWriteBack,
    output logic              outZero
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [15:0]       stallCycles
`endif
);

    // Whole beat packed into one vector so both entries move as a unit.
    localparam int PW = WB_W + M_W + 3 * DATA_W + REG_W + 1;

    logic [PW-1:0] in_pl;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          accept;
    logic          pop;
    logic [WB_W-1:0] main_wb;
    logic [M_W-1:0]  main_m;

    assign in_pl   = {WB, M, addResult, ALUResult, readData2, writeBack, zero};
    assign inReady = !skid_valid_q;
    assign outValid = main_valid_q;
    assign accept  = inValid && inReady;
    assign pop     = main_valid_q && outReady;

    assign {main_wb, main_m, outAddResult, outALUResult, outReadData2,
            outWriteBack, outZero} = main_q;

    // Control fields are gated so a bubble can never write memory or registers.
    assign outWB = main_valid_q ? main_wb : '0;
    assign outM  = main_valid_q ? main_m  : '0;

    // Next-state and payload load decisions; flush overrides every other event.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            // EMPTY: first beat goes straight into the main entry.
            if (accept) begin
                main_valid_d = 1'b1;
                main_d       = in_pl;
            end
        end else if (!skid_valid_q) begin
            // ONE: replace, park in skid, or drain.
            if (accept && pop) begin
                main_d = in_pl;
            end else if (accept) begin
                skid_valid_d = 1'b1;
                skid_d       = in_pl;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end
        end else begin
            // TWO: upstream is blocked; the skid beat moves up on a pop.
            if (pop) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end
    end

    // State and payload registers; reset clears data too so outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

`ifdef EXMEM_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stallCycles = stall_cnt_q;

    // Count cycles where a live beat is held back, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !outReady && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_exmem_skid_reg.sv
// Scoreboard bench for exmem_skid_reg. The reference model is a queue of
// live beats: at most two may be held, the front one is on the outputs,
// inReady means fewer than two are held, flush empties the queue.
module tb_exmem_skid_reg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int PW     = WB_W + M_W + 3 * DATA_W + REG_W + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              inValid = 1'b0;
    logic              inReady;
    logic [WB_W-1:0]   WB = '0;
    logic [M_W-1:0]    M = '0;
    logic [DATA_W-1:0] addResult = '0;
    logic [DATA_W-1:0] ALUResult = '0;
    logic [DATA_W-1:0] readData2 = '0;
    logic [REG_W-1:0]  writeBack = '0;
    logic              zero = 1'b0;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [WB_W-1:0]   outWB;
    logic [M_W-1:0]    outM;
    logic [DATA_W-1:0] outAddResult;
    logic [DATA_W-1:0] outALUResult;
    logic [DATA_W-1:0] outReadData2;
    logic [REG_W-1:0]  outWriteBack;
    logic              outZero;
`ifdef EXMEM_STALL_CNT_EN
    logic [15:0]       stallCycles;
    int unsigned       stall_model = 0;
`endif

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] out_pl;

    assign out_pl = {outWB, outM, outAddResult, outALUResult, outReadData2,
                     outWriteBack, outZero};

    exmem_skid_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W), .M_W(M_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
        .WB(WB), .M(M), .addResult(addResult), .ALUResult(ALUResult),
        .readData2(readData2), .writeBack(writeBack), .zero(zero),
        .outValid(outValid), .outReady(outReady), .outWB(outWB), .outM(outM),
        .outAddResult(outAddResult), .outALUResult(outALUResult),
        .outReadData2(outReadData2), .outWriteBack(outWriteBack), .outZero(outZero)
`ifdef EXMEM_STALL_CNT_EN
        , .stallCycles(stallCycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_pl();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    // Payload with only ALUResult set, for the directed sequences.
    function automatic logic [PW-1:0] alu_pl(input logic [DATA_W-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        p[DATA_W+REG_W+1 +: DATA_W] = v;
        p[PW-1 -: WB_W] = 2'b11;
        p[PW-WB_W-1 -: M_W] = 3'b101;
        return p;
    endfunction

    // One clock of stimulus; called just after a rising edge. The model is
    // updated just after the next rising edge, once the monitor has retired
    // any beat popped on that edge.
    task automatic step(input logic iv, input logic ordy, input logic fl,
                        input logic [PW-1:0] pl, output logic acc);
        inValid  = iv;
        outReady = ordy;
        flush    = fl;
        {WB, M, addResult, ALUResult, readData2, writeBack, zero} = pl;
        acc = iv && (exp_q.size() < 2);
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(pl);
        $display("step iv=%0b ordy=%0b flush=%0b acc=%0b held=%0d", iv, ordy, fl, acc, exp_q.size());
    endtask

    // Monitor: compares DUT outputs with the model mid-cycle and retires pops.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("outValid", 128'(outValid), 128'(exp_q.size() > 0));
            chk("inReady", 128'(inReady), 128'(exp_q.size() < 2));
            if (!outValid) chk("gated_ctl", 128'({outWB, outM}), 128'(0));
            if (outValid && exp_q.size() > 0) chk("payload", 128'(out_pl), 128'(exp_q[0]));
`ifdef EXMEM_STALL_CNT_EN
            chk("stallCycles", 128'(stallCycles), 128'(stall_model));
            if (exp_q.size() > 0 && !outReady && stall_model < 65535) stall_model++;
`endif
            if (outValid && outReady && exp_q.size() > 0) void'(exp_q.pop_front());
        end
    end

    initial begin
        logic a;
        // Reset state while rst is held.
        #3;
        chk("rst_outValid", 128'(outValid), 128'(0));
        chk("rst_inReady", 128'(inReady), 128'(1));
        chk("rst_payload", 128'(out_pl), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Stream 1..8 at full throughput.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1, 1'b0, alu_pl(DATA_W'(i)), a);
            chk("stream_accept", 128'(a), 128'(1));
        end
        step(1'b0, 1'b1, 1'b0, '0, a);

        // Stall: A into main, B into skid, C held off, then drain in order.
        step(1'b1, 1'b0, 1'b0, alu_pl(32'h10), a);
        step(1'b1, 1'b0, 1'b0, alu_pl(32'h20), a);
        step(1'b1, 1'b0, 1'b0, alu_pl(32'h30), a);
        chk("c_held_off", 128'(a), 128'(0));
        for (int i = 0; i < 4 && !a; i++) step(1'b1, 1'b1, 1'b0, alu_pl(32'h30), a);
        chk("c_accepted", 128'(a), 128'(1));
        step(1'b0, 1'b1, 1'b0, '0, a);
        step(1'b0, 1'b1, 1'b0, '0, a);

        // Flush while TWO with D presented: D must vanish.
        step(1'b1, 1'b0, 1'b0, alu_pl(32'h11), a);
        step(1'b1, 1'b0, 1'b0, alu_pl(32'h22), a);
        step(1'b1, 1'b0, 1'b1, alu_pl(32'h40), a);
        step(1'b0, 1'b1, 1'b0, '0, a);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 24) == 0), rand_pl(), a);
        end

`ifdef EXMEM_STALL_CNT_EN
        // Long stall to reach saturation, then a flush that must not clear it.
        step(1'b1, 1'b0, 1'b0, rand_pl(), a);
        for (int i = 0; i < 70000; i++) begin
            inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("stall_sat", 128'(stallCycles), 128'(16'hFFFF));
        step(1'b0, 1'b0, 1'b1, '0, a);
        step(1'b0, 1'b1, 1'b0, '0, a);
`endif

        // Asynchronous reset between edges while TWO.
        step(1'b1, 1'b0, 1'b0, rand_pl(), a);
        step(1'b1, 1'b0, 1'b0, rand_pl(), a);
        step(1'b0, 1'b0, 1'b0, '0, a);
        chk("two_before_rst", 128'(inReady), 128'(0));
        #2;
        rst = 1'b1;
        exp_q.delete();
`ifdef EXMEM_STALL_CNT_EN
        stall_model = 0;
`endif
        #1;
        chk("arst_outValid", 128'(outValid), 128'(0));
        chk("arst_inReady", 128'(inReady), 128'(1));
        chk("arst_payload", 128'(out_pl), 128'(0));
`ifdef EXMEM_STALL_CNT_EN
        chk("arst_stall", 128'(stallCycles), 128'(0));
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, rand_pl(), a);
        end
        step(1'b0, 1'b1, 1'b0, '0, a);
        step(1'b0, 1'b1, 1'b0, '0, a);
        step(1'b0, 1'b1, 1'b0, '0, a);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exmem_skid_reg.md
# exmem_skid_reg

Parametrised EX/MEM pipeline register for the MIPS datapath with a valid/ready handshake, a one-entry skid buffer and synchronous flush. It sits between the execute stage (ALU, branch adder) and the memory stage. It replaces the free-running EX/MEM latch, so the memory stage can stall without combinational ready paths back into execute. The branch logic can also squash in-flight instructions.

## Interface
Parameters:
- DATA_W, 32, width of addResult, ALUResult, readData2
- REG_W, 5, width of destination register index writeBack
- WB_W, 2, width of write-back control field
- M_W, 3, width of memory control field

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous squash of all held entries
- inValid  input  1  upstream beat present
- inReady  output  1  block can accept a beat; registered, equals !skidValid
- WB, M  input  WB_W / M_W  control fields
- addResult, ALUResult, readData2  input  DATA_W  execute results
- writeBack  input  REG_W  destination register
- zero  input  1  ALU zero flag
- outValid  output  1  main entry holds a live instruction
- outReady  input  1  downstream accepts the beat this cycle
- outWB, outM  output  WB_W / M_W  control; forced to 0 when outValid=0
- outAddResult, outALUResult, outReadData2  output  DATA_W  payload from main entry
- outWriteBack  output  REG_W; outZero  output  1  payload from main entry
- stallCycles  output  16  present only with EXMEM_STALL_CNT_EN

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Definitions: accept = inValid && inReady; pop = outValid && outReady.
- State is encoded by the valid bits: EMPTY (0,0), ONE (main only), TWO (main+skid).
- EMPTY:
  - accept -> ONE, main <= input.
- ONE:
  - accept && pop -> ONE, main <= input.
  - accept && !pop -> TWO, skid <= input.
  - !accept && pop -> EMPTY.
  - otherwise hold.
- TWO (inReady=0):
  - pop -> ONE, main <= skid.
  - otherwise hold.
- The skid entry never loads while TWO. Entry order is strictly preserved.
- flush=1 has priority over all other events:
  - Both valid bits clear and the next state is EMPTY.
  - A beat accepted in the same cycle is discarded.
  - A pop in the same cycle still completes downstream.
  - Payload registers are not cleared. Bubbles are harmless because outWB/outM are gated to 0.
- Payload registers load only on the transitions above. Data is not cleared on pop.

## Timing
- Reset (async, immediate):
  - all valid bits 0, so outValid=0 and inReady=1
  - every payload output 0, including outWB and outM
  - stallCycles 0
- Latency: a beat accepted in cycle N is on the outputs with outValid=1 in cycle N+1.
- Throughput: one beat per cycle while outReady=1.
- inReady depends only on register state. There is no combinational path from outReady or flush to inReady.
- Latency after stall release:
  - outReady low for one cycle while ONE and accepting -> TWO; inReady=0 from the next cycle.
  - outReady high again -> skid beat appears one cycle after the main beat pops.
- After flush in cycle N: outValid=0 and inReady=1 in cycle N+1.
- rst asserted mid-transfer discards both entries. Outputs go to reset values without waiting for clk.

## Configuration
- EXMEM_STALL_CNT_EN defined:
  - stallCycles port and counter are built.
  - The counter increments each cycle with outValid && !outReady.
  - It saturates at 16'hFFFF, clears only on rst, and is unaffected by flush.
- Not defined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Reset, then stream ALUResult=1..8 with inValid=1 and outReady=1 -> outputs 1..8 on consecutive cycles, each one cycle after accept; inReady stays 1.
- Accept A=0x10, hold outReady=0, then present B=0x20 -> B accepted into skid; inReady=0 next cycle; C=0x30 held off. Raise outReady -> A, B, C emerge in order with no loss or duplication.
- TWO state, flush=1 with inValid=1 carrying D=0x40 -> next cycle outValid=0, outWB=0, outM=0, inReady=1; D never appears.
- Assert rst asynchronously between edges while TWO -> outValid=0, inReady=1 and all outputs 0 before the next clk edge.
- EXMEM_STALL_CNT_EN:
  - outValid=1 with outReady=0 for 5 cycles -> stallCycles=5, unchanged by a subsequent flush.
  - Force 70000 stall cycles -> stallCycles holds at 16'hFFFF.
